pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage core.
- Generates the per-stage stall vector that holds or bubbles the pipeline registers, including the ID/EX register.
- Sequences multi-cycle EX operations (mult/div) with an internal down-counter.
- Arbitrates between load-use stalls from ID, multi-cycle stalls from EX and flush requests from MEM, and keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 6, width of multi-cycle length input and internal counter.
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stallreq_id  input  1  load-use hazard detected in ID (level).
- mc_start  input  1  EX holds a new multi-cycle op this cycle (pulse).
- mc_len  input  CNT_W  op length in cycles, sampled with mc_start.
- flush_req  input  1  exception/redirect from MEM (pulse).
- new_pc  input  32  redirect target, valid with flush_req.
- stall  output  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush  output  1  clear all pipeline registers this cycle.
- flush_pc  output  32  redirect target; new_pc when flush=1, else 0.
- mc_busy  output  1  multi-cycle op in progress (state MULTI).
- mc_done  output  1  one-cycle pulse: EX result is valid, pipeline released.
- perf_stall  output  PERF_W  saturating count of cycles with stall!=0.

Behaviour:
- State: IDLE, MULTI. The state register, counter cnt and perf_stall are the only flops. stall, flush, flush_pc and mc_done are combinational from state, cnt and the inputs. mc_busy = (state==MULTI).
- Reset (rst=1, asynchronous):
  - state=IDLE, cnt=0, perf_stall=0.
  - All outputs forced to 0 while rst is high, regardless of the inputs.
- Priority in every state: flush_req > multi-cycle > stallreq_id.
- IDLE:
  - flush_req=1: flush=1, flush_pc=new_pc, stall=000000. Stay in IDLE. mc_start is ignored.
  - Else mc_start=1 and mc_len!=0: stall=001111. Next state MULTI, cnt<=mc_len.
  - mc_start=1 with mc_len=0 is treated as a single-cycle op: no stall, no state change.
  - Else stallreq_id=1: stall=000111 (PC and IF/ID held, bubble into ID/EX).
  - Else stall=000000.
- MULTI:
  - flush_req=1: abort. flush=1, flush_pc=new_pc, stall=000000, mc_done=0. Next state IDLE, cnt<=0.
  - Else cnt>1: stall=001111, cnt<=cnt-1. stallreq_id and mc_start are ignored.
  - Else cnt==1: mc_done=1, stall=000000. Next state IDLE, cnt<=0.
  - A new mc_start in this same cycle is not accepted; the issuing stage re-presents it the next cycle.
- Latency:
  - The mc_start cycle is T0. Stall is asserted for exactly mc_len cycles (T0..T(mc_len-1)).
  - mc_done pulses at T(mc_len) and stall is released in that same cycle.
  - Maximum length is 2^CNT_W-1.
- perf_stall increments by 1 on each rising edge where stall!=0 and rst=0. It holds at all-ones (no wrap).
- Reset asserted mid-MULTI: immediate return to IDLE, all outputs 0, mc_done never pulses.
- stall bits 4 and 5 are always 0 in this revision (MEM/WB never stalled).

Test Plan:
- Reset: rst=1 with all request inputs=1 -> stall=0, flush=0, flush_pc=0, mc_busy=0, mc_done=0, perf_stall=0; after release, IDLE and stall follows the inputs.
- Load-use: stallreq_id=1 for 2 cycles -> stall=000111 for those 2 cycles; then 000000, perf_stall=2.
- Divide: mc_start=1, mc_len=5 at T0 -> stall=001111 T0..T4, mc_busy=1 T1..T5, mc_done=1 only at T5 with stall=0; stallreq_id=1 during T1..T4 has no effect; perf_stall=5.
- Abort: mc_len=10, flush_req=1 with new_pc=32'hBFC00380 at T3 -> flush=1, flush_pc=32'hBFC00380, stall=0 at T3; IDLE at T4; no mc_done pulse.
- Simultaneous events in IDLE:
  - mc_start=1, mc_len=3 with stallreq_id=1 -> stall=001111.
  - Same cycle plus flush_req=1 -> flush wins, stall=0, state stays IDLE.
  - mc_start with mc_len=0 -> no stall.
- Saturation: preload by running continuous stalls past 65535 cycles -> perf_stall holds at 16'hFFFF; async rst pulse mid-MULTI clears it and the state immediately.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core: load-use bubbles, multi-cycle
// EX op sequencing via down-counter, MEM redirect flushes and a saturating stall counter.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | single-cycle flow; load-use stalls and new mult/div accepted
// S_MULTI | mult/div in EX; cnt_q holds cycles left before result valid

module pipe_stall_ctrl #(
   parameter int CNT_W  = 6,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              mc_start,
   input  logic [CNT_W-1:0]  mc_len,
   input  logic              flush_req,
   input  logic [31:0]       new_pc,
   output logic [5:0]        stall,
   output logic              flush,
   output logic [31:0]       flush_pc,
   output logic              mc_busy,
   output logic              mc_done,
   output logic [PERF_W-1:0] perf_stall
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_MULTI = 1'b1
   } state_t;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_LU   = 6'b000111;
   localparam logic [5:0] STALL_MC   = 6'b001111;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PERF_W-1:0]   perf_stall_q, perf_stall_d;

   logic [5:0]          stall_int;
   logic                flush_int;
   logic                done_int;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         perf_stall_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_int = STALL_NONE;
      flush_int = 1'b0;
      done_int  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               flush_int = 1'b1;
            end else if (mc_start && (mc_len != '0)) begin
               stall_int = STALL_MC;
               state_d   = S_MULTI;
               cnt_d     = mc_len;
            end else if (stallreq_id) begin
               stall_int = STALL_LU;
            end
         end
         S_MULTI: begin
            if (flush_req) begin
               flush_int = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else if (cnt_q > CNT_ONE) begin
               stall_int = STALL_MC;
               cnt_d     = cnt_q - CNT_ONE;
            end else begin
               // cnt_q==0 cannot be reached here; treated as completion for safety
               done_int = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      perf_stall_d = perf_stall_q;
      if ((stall_int != STALL_NONE) && (perf_stall_q != {PERF_W{1'b1}}))
         perf_stall_d = perf_stall_q + PERF_W'(1);
   end

   // outputs masked while reset is held so request inputs cannot leak through
   assign stall      = rst ? STALL_NONE : stall_int;
   assign flush      = flush_int & ~rst;
   assign flush_pc   = (flush_int && !rst) ? new_pc : 32'h0;
   assign mc_done    = done_int & ~rst;
   assign mc_busy    = (state_q == S_MULTI) && !rst;
   assign perf_stall = perf_stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed table, corner sequences and
// randomized traffic against a timestamp-based reference model.

module tb_pipe_stall_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_id;
   logic        mc_start;
   logic [5:0]  mc_len;
   logic        flush_req;
   logic [31:0] new_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        mc_busy;
   logic        mc_done;
   logic [15:0] perf_stall;

   int errors = 0;
   int checks = 0;

   pipe_stall_ctrl #(.CNT_W(6), .PERF_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .stallreq_id (stallreq_id),
      .mc_start    (mc_start),
      .mc_len      (mc_len),
      .flush_req   (flush_req),
      .new_pc      (new_pc),
      .stall       (stall),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .mc_busy     (mc_busy),
      .mc_done     (mc_done),
      .perf_stall  (perf_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: a multi-cycle op issued at cycle c completes at cycle c+len
   bit          m_busy;
   int          m_done_at;
   int          m_cyc;
   int          m_perf;
   bit          n_busy;
   int          n_done_at;
   logic [5:0]  e_stall;
   logic        e_flush;
   logic [31:0] e_pc;
   logic        e_busy;
   logic        e_done;
   logic [15:0] e_perf;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_eval();
      if (rst) begin
         m_busy = 1'b0;
         m_perf = 0;
      end
      e_stall = 6'd0; e_flush = 1'b0; e_pc = 32'd0; e_done = 1'b0;
      e_busy  = m_busy && !rst;
      n_busy = m_busy; n_done_at = m_done_at;
      if (!rst) begin
         if (flush_req) begin
            e_flush = 1'b1; e_pc = new_pc; n_busy = 1'b0;
         end else if (m_busy) begin
            if (m_cyc >= m_done_at) begin
               e_done = 1'b1; n_busy = 1'b0;
            end else begin
               e_stall = 6'b001111;
            end
         end else if (mc_start && mc_len != 0) begin
            e_stall = 6'b001111; n_busy = 1'b1; n_done_at = m_cyc + int'(mc_len);
         end else if (stallreq_id) begin
            e_stall = 6'b000111;
         end
      end
      e_perf = 16'(m_perf);
   endtask

   task automatic model_cmp();
      chk("stall", 64'(stall), 64'(e_stall));
      chk("flush", 64'(flush), 64'(e_flush));
      chk("flush_pc", 64'(flush_pc), 64'(e_pc));
      chk("mc_busy", 64'(mc_busy), 64'(e_busy));
      chk("mc_done", 64'(mc_done), 64'(e_done));
      chk("perf_stall", 64'(perf_stall), 64'(e_perf));
   endtask

   task automatic advance();
      @(posedge clk);
      if (!rst) begin
         if (e_stall != 6'd0 && m_perf < 65535) m_perf++;
         m_busy = n_busy; m_done_at = n_done_at;
      end
      m_cyc++;
      #1;
   endtask

   task automatic setin(input logic r, input logic s, input logic st, input logic [5:0] l,
                        input logic f, input logic [31:0] pc);
      rst = r; stallreq_id = s; mc_start = st; mc_len = l; flush_req = f; new_pc = pc;
   endtask

   // one cycle: inputs already applied; check at negedge, then clock the model
   task automatic cyc(input bit do_cmp);
      @(negedge clk);
      model_eval();
      if (do_cmp) model_cmp();
      advance();
   endtask

   typedef struct {
      logic        rst, sreq, start;
      logic [5:0]  len;
      logic        fl;
      logic [31:0] pc;
      logic [5:0]  x_stall;
      logic        x_flush;
      logic [31:0] x_pc;
      logic        x_busy, x_done;
      logic [15:0] x_perf;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic r, logic s, logic st, logic [5:0] l, logic f, logic [31:0] pc,
                               logic [5:0] xs, logic xf, logic [31:0] xpc, logic xb, logic xd,
                               logic [15:0] xp);
      vec_t v;
      v.rst = r; v.sreq = s; v.start = st; v.len = l; v.fl = f; v.pc = pc;
      v.x_stall = xs; v.x_flush = xf; v.x_pc = xpc; v.x_busy = xb; v.x_done = xd; v.x_perf = xp;
      return v;
   endfunction

   initial begin
      m_busy = 0; m_done_at = 0; m_cyc = 0; m_perf = 0;
      setin(1, 1, 1, 6'd5, 1, 32'hFFFF_FFFF);

      //                 rst sreq st len  fl pc             stall     fl xpc            busy done perf
      vecs[0]  = mk(1, 1, 1, 6'd5, 1, 32'hFFFF_FFFF, 6'b000000, 0, 32'h0,         0, 0, 16'd0);
      vecs[1]  = mk(0, 1, 0, 6'd0, 0, 32'h0,         6'b000111, 0, 32'h0,         0, 0, 16'd0);
      vecs[2]  = mk(0, 1, 0, 6'd0, 0, 32'h0,         6'b000111, 0, 32'h0,         0, 0, 16'd1);
      vecs[3]  = mk(0, 0, 0, 6'd0, 0, 32'h0,         6'b000000, 0, 32'h0,         0, 0, 16'd2);
      vecs[4]  = mk(0, 0, 1, 6'd5, 0, 32'h0,         6'b001111, 0, 32'h0,         0, 0, 16'd2);
      vecs[5]  = mk(0, 1, 0, 6'd0, 0, 32'h0,         6'b001111, 0, 32'h0,         1, 0, 16'd3);
      vecs[6]  = mk(0, 1, 1, 6'd2, 0, 32'h0,         6'b001111, 0, 32'h0,         1, 0, 16'd4);
      vecs[7]  = mk(0, 1, 0, 6'd0, 0, 32'h0,         6'b001111, 0, 32'h0,         1, 0, 16'd5);
      vecs[8]  = mk(0, 1, 0, 6'd0, 0, 32'h0,         6'b001111, 0, 32'h0,         1, 0, 16'd6);
      vecs[9]  = mk(0, 0, 0, 6'd0, 0, 32'h0,         6'b000000, 0, 32'h0,         1, 1, 16'd7);
      vecs[10] = mk(0, 0, 0, 6'd0, 0, 32'h0,         6'b000000, 0, 32'h0,         0, 0, 16'd7);
      vecs[11] = mk(0, 1, 1, 6'd3, 0, 32'h0,         6'b001111, 0, 32'h0,         0, 0, 16'd7);
      vecs[12] = mk(0, 0, 0, 6'd0, 1, 32'h1234_5678, 6'b000000, 1, 32'h1234_5678, 1, 0, 16'd8);
      vecs[13] = mk(0, 0, 1, 6'd0, 0, 32'h0,         6'b000000, 0, 32'h0,         0, 0, 16'd8);
      vecs[14] = mk(0, 1, 1, 6'd3, 1, 32'hBFC0_0380, 6'b000000, 1, 32'hBFC0_0380, 0, 0, 16'd8);
      vecs[15] = mk(0, 0, 0, 6'd0, 0, 32'h0,         6'b000000, 0, 32'h0,         0, 0, 16'd8);

      for (int i = 0; i < 16; i++) begin
         setin(vecs[i].rst, vecs[i].sreq, vecs[i].start, vecs[i].len, vecs[i].fl, vecs[i].pc);
         @(negedge clk);
         chk($sformatf("tbl%0d.stall", i), 64'(stall), 64'(vecs[i].x_stall));
         chk($sformatf("tbl%0d.flush", i), 64'(flush), 64'(vecs[i].x_flush));
         chk($sformatf("tbl%0d.flush_pc", i), 64'(flush_pc), 64'(vecs[i].x_pc));
         chk($sformatf("tbl%0d.mc_busy", i), 64'(mc_busy), 64'(vecs[i].x_busy));
         chk($sformatf("tbl%0d.mc_done", i), 64'(mc_done), 64'(vecs[i].x_done));
         chk($sformatf("tbl%0d.perf", i), 64'(perf_stall), 64'(vecs[i].x_perf));
         model_eval();
         model_cmp();
         advance();
      end

      // abort: mc_len=10 flushed at T3, no done afterwards
      setin(1, 0, 0, 6'd0, 0, 32'h0); cyc(1);
      setin(0, 0, 1, 6'd10, 0, 32'h0); cyc(1);
      setin(0, 0, 0, 6'd0, 0, 32'h0); cyc(1); cyc(1);
      setin(0, 0, 0, 6'd0, 1, 32'hBFC0_0380);
      @(negedge clk);
      chk("abort.flush", 64'(flush), 64'd1);
      chk("abort.flush_pc", 64'(flush_pc), 64'hBFC0_0380);
      chk("abort.stall", 64'(stall), 64'd0);
      chk("abort.mc_done", 64'(mc_done), 64'd0);
      model_eval(); model_cmp(); advance();
      setin(0, 0, 0, 6'd0, 0, 32'h0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort.idle_busy", 64'(mc_busy), 64'd0);
         chk("abort.no_done", 64'(mc_done), 64'd0);
         model_eval(); model_cmp(); advance();
      end

      // length 1 and maximum length
      setin(0, 0, 1, 6'd1, 0, 32'h0); cyc(1);
      setin(0, 0, 0, 6'd0, 0, 32'h0); cyc(1); cyc(1);
      setin(0, 0, 1, 6'd63, 0, 32'h0); cyc(1);
      setin(0, 1, 0, 6'd0, 0, 32'h0);
      for (int i = 0; i < 66; i++) cyc(1);

      // saturation: continuous load-use stall past 65535 cycles
      setin(1, 0, 0, 6'd0, 0, 32'h0); cyc(1);
      setin(0, 1, 0, 6'd0, 0, 32'h0);
      for (int i = 0; i < 65540; i++) cyc(0);
      @(negedge clk);
      chk("sat.perf", 64'(perf_stall), 64'hFFFF);
      model_eval(); model_cmp(); advance();
      setin(0, 0, 1, 6'd20, 0, 32'h0); cyc(1);
      setin(0, 0, 0, 6'd0, 0, 32'h0); cyc(1); cyc(1);
      chk("sat.busy_before_rst", 64'(mc_busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid.stall", 64'(stall), 64'd0);
      chk("rst_mid.mc_busy", 64'(mc_busy), 64'd0);
      chk("rst_mid.perf", 64'(perf_stall), 64'd0);
      chk("rst_mid.mc_done", 64'(mc_done), 64'd0);
      cyc(1);
      setin(0, 0, 0, 6'd0, 0, 32'h0);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         chk("rst_mid.no_done", 64'(mc_done), 64'd0);
         model_eval(); model_cmp(); advance();
      end

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] l;
         l = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 9));
         setin(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), l, ($urandom_range(0, 19) == 0), $urandom);
         cyc(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
